// File: rtl/avg_pool_sequencer.sv
// Time-multiplexes one 2x2 average-pool unit over a D x H x W feature map: fetches each window's
// four words, issues them under a credit limit, and writes returned averages in order.
module avg_pool_sequencer_chk #(
    parameter int MAX_OUT = 4
) (
    input logic       clk,
    input logic       reset,
    input logic [3:0] out_cnt,
    input logic       issue,
    input logic       ret
);
    a_no_overflow:  assert property (@(posedge clk) disable iff (reset) (out_cnt <= 4'(MAX_OUT)));
    a_no_underflow: assert property (@(posedge clk) disable iff (reset) !(out_cnt == 4'd0 && ret && !issue));
endmodule

module avg_pool_sequencer #(
    parameter int DW      = 16,
    parameter int D       = 16,
    parameter int H       = 10,
    parameter int W       = 10,
    parameter int MAX_OUT = 4,
    parameter int AW      = 11
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    output logic            busy,
    output logic            done,
    output logic            rd_en,
    output logic [AW-1:0]   rd_addr,
    input  logic [DW-1:0]   rd_data,
    output logic            pu_in_valid,
    input  logic            pu_in_ready,
    output logic [4*DW-1:0] pu_in_data,
    input  logic            pu_out_valid,
    input  logic [DW-1:0]   pu_out_data,
    output logic            wr_en,
    output logic [AW-1:0]   wr_addr,
    output logic [DW-1:0]   wr_data
);
    localparam int OH = H / 2;
    localparam int OW = W / 2;
    localparam int CW = $clog2(D) + 1;
    localparam int RW = $clog2(OH) + 1;
    localparam int XW = $clog2(OW) + 1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CHECK = 3'd1,
        S_FETCH = 3'd2,
        S_CAPT  = 3'd3,
        S_ISSUE = 3'd4,
        S_DRAIN = 3'd5,
        S_DONE  = 3'd6
    } state_e;

    state_e        state_q, state_d;
    logic [1:0]    k_q, k_d;
    logic [CW-1:0] c_q, c_d;
    logic [RW-1:0] orow_q, orow_d;
    logic [XW-1:0] ocol_q, ocol_d;
    logic [3:0]    out_cnt_q, out_cnt_d;
    logic [AW-1:0] wr_cnt_q, wr_cnt_d;
    logic          busy_q, busy_d, done_q, done_d;
    logic          rd_en_q, rd_en_d, pu_in_valid_q, pu_in_valid_d;
    logic [AW-1:0] rd_addr_q, rd_addr_d;
    logic          cap_v_q, cap_v_d;
    logic [1:0]    cap_k_q, cap_k_d;
    logic [DW-1:0] slot_q [4];
    logic [DW-1:0] slot_d [4];
    logic          wr_en_q, wr_en_d;
    logic [AW-1:0] wr_addr_q, wr_addr_d;
    logic [DW-1:0] wr_data_q, wr_data_d;

    logic          issue_hs_s, ret_s, last_win_s, start_ok_s;
    logic [AW-1:0] base_s, off_s;

    assign issue_hs_s = pu_in_valid_q & pu_in_ready;
    assign ret_s      = busy_q & pu_out_valid;
    assign start_ok_s = (state_q == S_IDLE) & start;
    assign last_win_s = (c_q == CW'(D - 1)) & (orow_q == RW'(OH - 1)) & (ocol_q == XW'(OW - 1));
    assign base_s     = AW'(c_q) * AW'(H * W) + AW'(orow_q) * AW'(2 * W) + AW'(ocol_q) * AW'(2);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  state_d = start ? S_CHECK : S_IDLE;
            S_CHECK: state_d = (out_cnt_q < 4'(MAX_OUT)) ? S_FETCH : S_CHECK;
            S_FETCH: state_d = (k_q == 2'd3) ? S_CAPT : S_FETCH;
            S_CAPT:  state_d = S_ISSUE;
            S_ISSUE: state_d = issue_hs_s ? (last_win_s ? S_DRAIN : S_CHECK) : S_ISSUE;
            S_DRAIN: state_d = (out_cnt_q == 4'd0) ? S_DONE : S_DRAIN;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        k_d    = (state_q == S_FETCH) ? k_q + 2'd1 : 2'd0;
        c_d    = c_q;
        orow_d = orow_q;
        ocol_d = ocol_q;
        // Window walk: ocol fastest, then orow, then channel.
        if (start_ok_s) begin
            c_d    = '0;
            orow_d = '0;
            ocol_d = '0;
        end else if (issue_hs_s) begin
            if (ocol_q == XW'(OW - 1)) begin
                ocol_d = '0;
                if (orow_q == RW'(OH - 1)) begin
                    orow_d = '0;
                    c_d    = last_win_s ? '0 : c_q + CW'(1);
                end else begin
                    orow_d = orow_q + RW'(1);
                end
            end else begin
                ocol_d = ocol_q + XW'(1);
            end
        end else begin
            c_d = c_q;
        end

        case (k_d)
            2'd0:    off_s = '0;
            2'd1:    off_s = AW'(1);
            2'd2:    off_s = AW'(W);
            2'd3:    off_s = AW'(W + 1);
            default: off_s = '0;
        endcase

        out_cnt_d     = out_cnt_q + {3'd0, issue_hs_s} - {3'd0, ret_s};
        wr_cnt_d      = start_ok_s ? '0 : (ret_s ? wr_cnt_q + AW'(1) : wr_cnt_q);
        busy_d        = (state_d != S_IDLE) && (state_d != S_DONE);
        done_d        = (state_d == S_DONE);
        pu_in_valid_d = (state_d == S_ISSUE);
        rd_en_d       = (state_d == S_FETCH);
        rd_addr_d     = rd_en_d ? base_s + off_s : rd_addr_q;
        // Read data arrives one cycle after the strobe; remember which slot it belongs to.
        cap_v_d       = rd_en_q;
        cap_k_d       = k_q;
        for (int i = 0; i < 4; i++) begin
            slot_d[i] = (cap_v_q && (cap_k_q == 2'(i))) ? rd_data : slot_q[i];
        end
        wr_en_d       = ret_s;
        wr_addr_d     = ret_s ? wr_cnt_q : wr_addr_q;
        wr_data_d     = ret_s ? pu_out_data : wr_data_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            k_q           <= 2'd0;
            c_q           <= '0;
            orow_q        <= '0;
            ocol_q        <= '0;
            out_cnt_q     <= 4'd0;
            wr_cnt_q      <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            pu_in_valid_q <= 1'b0;
            rd_en_q       <= 1'b0;
            rd_addr_q     <= '0;
            cap_v_q       <= 1'b0;
            cap_k_q       <= 2'd0;
            for (int i = 0; i < 4; i++) begin
                slot_q[i] <= '0;
            end
            wr_en_q       <= 1'b0;
            wr_addr_q     <= '0;
            wr_data_q     <= '0;
        end else begin
            k_q           <= k_d;
            c_q           <= c_d;
            orow_q        <= orow_d;
            ocol_q        <= ocol_d;
            out_cnt_q     <= out_cnt_d;
            wr_cnt_q      <= wr_cnt_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            pu_in_valid_q <= pu_in_valid_d;
            rd_en_q       <= rd_en_d;
            rd_addr_q     <= rd_addr_d;
            cap_v_q       <= cap_v_d;
            cap_k_q       <= cap_k_d;
            for (int i = 0; i < 4; i++) begin
                slot_q[i] <= slot_d[i];
            end
            wr_en_q       <= wr_en_d;
            wr_addr_q     <= wr_addr_d;
            wr_data_q     <= wr_data_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign rd_en       = rd_en_q;
    assign rd_addr     = rd_addr_q;
    assign pu_in_valid = pu_in_valid_q;
    assign pu_in_data  = {slot_q[3], slot_q[2], slot_q[1], slot_q[0]};
    assign wr_en       = wr_en_q;
    assign wr_addr     = wr_addr_q;
    assign wr_data     = wr_data_q;

    avg_pool_sequencer_chk #(.MAX_OUT(MAX_OUT)) u_chk (
        .clk     (clk),
        .reset   (reset),
        .out_cnt (out_cnt_q),
        .issue   (issue_hs_s),
        .ret     (ret_s)
    );
endmodule

// File: tb/tb_avg_pool_sequencer.sv
// Scoreboard bench: a small (2x4x4) and a default-size sequencer, each with a RAM and pool-unit model.
`timescale 1ns/1ps
module tb_avg_pool_sequencer;
    localparam int SD = 2,  SH = 4,  SW = 4,  SM = 2;
    localparam int LD = 16, LH = 10, LW = 10, LM = 4;
    localparam int SN = SD * SH * SW;
    localparam int LN = LD * LH * LW;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errors = 0;

    logic        s_reset, s_start, s_busy, s_done, s_rd_en, s_pu_in_valid, s_pu_in_ready;
    logic        s_pu_out_valid, s_wr_en;
    logic [10:0] s_rd_addr, s_wr_addr;
    logic [15:0] s_rd_data, s_pu_out_data, s_wr_data;
    logic [63:0] s_pu_in_data;
    logic        l_reset, l_start, l_busy, l_done, l_rd_en, l_pu_in_valid, l_pu_in_ready;
    logic        l_pu_out_valid, l_wr_en;
    logic [10:0] l_rd_addr, l_wr_addr;
    logic [15:0] l_rd_data, l_pu_out_data, l_wr_data;
    logic [63:0] l_pu_in_data;

    avg_pool_sequencer #(.DW(16), .D(SD), .H(SH), .W(SW), .MAX_OUT(SM), .AW(11)) u_small (
        .clk(clk), .reset(s_reset), .start(s_start), .busy(s_busy), .done(s_done),
        .rd_en(s_rd_en), .rd_addr(s_rd_addr), .rd_data(s_rd_data),
        .pu_in_valid(s_pu_in_valid), .pu_in_ready(s_pu_in_ready), .pu_in_data(s_pu_in_data),
        .pu_out_valid(s_pu_out_valid), .pu_out_data(s_pu_out_data),
        .wr_en(s_wr_en), .wr_addr(s_wr_addr), .wr_data(s_wr_data));

    avg_pool_sequencer #(.DW(16), .D(LD), .H(LH), .W(LW), .MAX_OUT(LM), .AW(11)) u_large (
        .clk(clk), .reset(l_reset), .start(l_start), .busy(l_busy), .done(l_done),
        .rd_en(l_rd_en), .rd_addr(l_rd_addr), .rd_data(l_rd_data),
        .pu_in_valid(l_pu_in_valid), .pu_in_ready(l_pu_in_ready), .pu_in_data(l_pu_in_data),
        .pu_out_valid(l_pu_out_valid), .pu_out_data(l_pu_out_data),
        .wr_en(l_wr_en), .wr_addr(l_wr_addr), .wr_data(l_wr_data));

    logic [15:0] s_mem [SN];
    logic [15:0] l_mem [LN];
    int          s_exp_rd[$], s_exp_wa[$], l_exp_rd[$], l_exp_wa[$];
    logic [15:0] s_exp_wd[$], l_exp_wd[$];
    int          s_pq_due[$], l_pq_due[$];
    logic [15:0] s_pq_data[$], l_pq_data[$];
    int  s_rd_cnt = 0, s_wr_cnt = 0, s_done_cnt = 0, s_issue_cnt = 0;
    int  l_wr_cnt = 0, l_done_cnt = 0;
    bit  s_stall_arm = 1'b0, s_withhold = 1'b0, s_rand_ready = 1'b0, s_inject_idle = 1'b0;
    int  s_stall_left = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic unexpected(input string name, input logic [63:0] act);
        n_checks++;
        n_errors++;
        $display("FAIL %s: got unexpected %0h expected nothing", name, act);
    endtask

    function automatic logic [15:0] word(input bit big, input int a);
        if (big) return l_mem[a];
        else return s_mem[a];
    endfunction

    // Reference: every window in channel/row/col order reads its 2x2 block and writes its sum.
    task automatic push_frame(input bit big);
        int d, h, w, idx, b;
        logic [15:0] sum;
        d = big ? LD : SD;
        h = big ? LH : SH;
        w = big ? LW : SW;
        idx = 0;
        for (int c = 0; c < d; c++)
            for (int orow = 0; orow < h / 2; orow++)
                for (int ocol = 0; ocol < w / 2; ocol++) begin
                    b = c * h * w + 2 * orow * w + 2 * ocol;
                    sum = word(big, b) + word(big, b + 1) + word(big, b + w) + word(big, b + w + 1);
                    if (big) begin
                        l_exp_rd.push_back(b); l_exp_rd.push_back(b + 1);
                        l_exp_rd.push_back(b + w); l_exp_rd.push_back(b + w + 1);
                        l_exp_wa.push_back(idx); l_exp_wd.push_back(sum);
                    end else begin
                        s_exp_rd.push_back(b); s_exp_rd.push_back(b + 1);
                        s_exp_rd.push_back(b + w); s_exp_rd.push_back(b + w + 1);
                        s_exp_wa.push_back(idx); s_exp_wd.push_back(sum);
                    end
                    idx++;
                end
    endtask

    // Small instance: RAM, pool unit (ready policy, 3-cycle latency) and stall-phase checks.
    initial begin : model_s
        bit pend;
        int pend_addr;
        s_rd_data = 16'h0; s_pu_in_ready = 1'b1; s_pu_out_valid = 1'b0; s_pu_out_data = 16'h0;
        pend = 1'b0; pend_addr = 0;
        forever begin
            @(negedge clk);
            s_rd_data = pend ? s_mem[pend_addr] : 16'h0;
            pend = s_rd_en;
            pend_addr = int'(s_rd_addr);
            if (s_stall_arm && s_pu_in_valid) begin
                s_stall_left = 5;
                s_stall_arm = 1'b0;
            end
            if (s_stall_left > 0) begin
                s_pu_in_ready = 1'b0;
                chk("stall_valid_held", 64'(s_pu_in_valid), 64'd1);
                chk("stall_data_stable", s_pu_in_data, {16'd5, 16'd4, 16'd1, 16'd0});
                chk("stall_no_rd", 64'(s_rd_en), 64'd0);
                s_stall_left--;
            end else begin
                s_pu_in_ready = s_rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            end
            if (s_pu_in_valid && s_pu_in_ready) begin
                s_issue_cnt++;
                s_pq_due.push_back(cyc + 3);
                s_pq_data.push_back(s_pu_in_data[15:0] + s_pu_in_data[31:16] +
                                    s_pu_in_data[47:32] + s_pu_in_data[63:48]);
            end
            if (!s_withhold && s_pq_due.size() > 0 && s_pq_due[0] <= cyc) begin
                s_pu_out_valid = 1'b1;
                s_pu_out_data = s_pq_data.pop_front();
                void'(s_pq_due.pop_front());
            end else if (s_inject_idle) begin
                s_pu_out_valid = 1'b1;
                s_pu_out_data = 16'hDEAD;
                s_inject_idle = 1'b0;
            end else begin
                s_pu_out_valid = 1'b0;
            end
        end
    end

    // Large instance: RAM and pool unit with random ready and random 1..6 cycle latency.
    initial begin : model_l
        bit pend;
        int pend_addr;
        l_rd_data = 16'h0; l_pu_in_ready = 1'b1; l_pu_out_valid = 1'b0; l_pu_out_data = 16'h0;
        pend = 1'b0; pend_addr = 0;
        forever begin
            @(negedge clk);
            l_rd_data = pend ? l_mem[pend_addr] : 16'h0;
            pend = l_rd_en;
            pend_addr = int'(l_rd_addr);
            l_pu_in_ready = ($urandom_range(0, 3) != 0);
            if (l_pu_in_valid && l_pu_in_ready) begin
                l_pq_due.push_back(cyc + int'($urandom_range(1, 6)));
                l_pq_data.push_back(l_pu_in_data[15:0] + l_pu_in_data[31:16] +
                                    l_pu_in_data[47:32] + l_pu_in_data[63:48]);
            end
            if (l_pq_due.size() > 0 && l_pq_due[0] <= cyc && $urandom_range(0, 3) != 0) begin
                l_pu_out_valid = 1'b1;
                l_pu_out_data = l_pq_data.pop_front();
                void'(l_pq_due.pop_front());
            end else begin
                l_pu_out_valid = 1'b0;
            end
        end
    end

    // Monitors: pop expected reads/writes whenever the DUT presents a strobe.
    initial begin : mon
        forever begin
            @(negedge clk);
            if (s_rd_en) begin
                s_rd_cnt++;
                if (s_exp_rd.size() > 0) chk("s_rd_addr", 64'(s_rd_addr), 64'(s_exp_rd.pop_front()));
                else unexpected("s_rd_extra", 64'(s_rd_addr));
            end
            if (s_wr_en) begin
                s_wr_cnt++;
                if (s_exp_wa.size() > 0) begin
                    chk("s_wr_addr", 64'(s_wr_addr), 64'(s_exp_wa.pop_front()));
                    chk("s_wr_data", 64'(s_wr_data), 64'(s_exp_wd.pop_front()));
                end else unexpected("s_wr_extra", 64'(s_wr_addr));
            end
            if (s_done) begin
                s_done_cnt++;
                chk("s_done_busy_low", 64'(s_busy), 64'd0);
            end
            if (l_rd_en) begin
                if (l_exp_rd.size() > 0) chk("l_rd_addr", 64'(l_rd_addr), 64'(l_exp_rd.pop_front()));
                else unexpected("l_rd_extra", 64'(l_rd_addr));
            end
            if (l_wr_en) begin
                l_wr_cnt++;
                if (l_exp_wa.size() > 0) begin
                    chk("l_wr_addr", 64'(l_wr_addr), 64'(l_exp_wa.pop_front()));
                    chk("l_wr_data", 64'(l_wr_data), 64'(l_exp_wd.pop_front()));
                end else unexpected("l_wr_extra", 64'(l_wr_addr));
            end
            if (l_done) l_done_cnt++;
        end
    end

    task automatic s_kick();
        push_frame(1'b0);
        s_start = 1'b1;
        @(negedge clk);
        s_start = 1'b0;
    endtask

    task automatic s_wait_done(input string name);
        int n;
        n = 0;
        while (s_done !== 1'b1 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (s_done !== 1'b1) begin
            n_checks++; n_errors++;
            $display("FAIL %s_timeout: no done after %0d cycles, expected done", name, n);
        end
        repeat (3) @(negedge clk);
        chk({name, "_busy_after"}, 64'(s_busy), 64'd0);
        chk({name, "_rd_left"}, 64'(s_exp_rd.size()), 64'd0);
        chk({name, "_wr_left"}, 64'(s_exp_wa.size()), 64'd0);
    endtask

    task automatic s_check_zero(input string name);
        chk({name, "_busy"}, 64'(s_busy), 64'd0);
        chk({name, "_done"}, 64'(s_done), 64'd0);
        chk({name, "_rd_en"}, 64'(s_rd_en), 64'd0);
        chk({name, "_pu_in_valid"}, 64'(s_pu_in_valid), 64'd0);
        chk({name, "_wr_en"}, 64'(s_wr_en), 64'd0);
        chk({name, "_rd_addr"}, 64'(s_rd_addr), 64'd0);
        chk({name, "_wr_addr"}, 64'(s_wr_addr), 64'd0);
        chk({name, "_pu_in_data"}, s_pu_in_data, 64'd0);
    endtask

    initial begin : main
        int d0, r0, i0, w0, n;
        s_reset = 1'b1; l_reset = 1'b1; s_start = 1'b0; l_start = 1'b0;
        for (int i = 0; i < SN; i++) s_mem[i] = 16'(i);
        for (int i = 0; i < LN; i++) l_mem[i] = 16'($urandom);
        repeat (3) @(negedge clk);
        s_reset = 1'b0; l_reset = 1'b0;
        @(negedge clk);
        s_check_zero("reset");

        // Identity buffer, always-ready pool unit.
        d0 = s_done_cnt;
        s_kick();
        s_wait_done("t1");
        chk("t1_done_once", 64'(s_done_cnt - d0), 64'd1);
        chk("t1_writes", 64'(s_wr_cnt), 64'd8);

        // Pool unit refuses the first operand set for five cycles.
        s_stall_arm = 1'b1;
        s_kick();
        s_wait_done("t2");

        // Results withheld: credit limit must stop fetching after two issues.
        s_withhold = 1'b1;
        r0 = s_rd_cnt; i0 = s_issue_cnt;
        s_kick();
        repeat (40) @(negedge clk);
        chk("t3_issues", 64'(s_issue_cnt - i0), 64'd2);
        chk("t3_reads", 64'(s_rd_cnt - r0), 64'd8);
        repeat (20) @(negedge clk);
        chk("t3_reads_still", 64'(s_rd_cnt - r0), 64'd8);
        chk("t3_busy", 64'(s_busy), 64'd1);
        s_withhold = 1'b0;
        s_wait_done("t3");

        // Reset mid-frame, then a clean frame.
        s_kick();
        repeat (19) @(negedge clk);
        s_reset = 1'b1;
        @(negedge clk);
        s_reset = 1'b0;
        s_check_zero("t4_reset");
        s_exp_rd.delete(); s_exp_wa.delete(); s_exp_wd.delete();
        s_pq_due.delete(); s_pq_data.delete();
        repeat (3) @(negedge clk);
        d0 = s_done_cnt;
        s_kick();
        s_wait_done("t4");
        chk("t4_done_once", 64'(s_done_cnt - d0), 64'd1);

        // start while busy and pu_out_valid while idle must have no effect.
        d0 = s_done_cnt;
        s_kick();
        repeat (15) @(negedge clk);
        s_start = 1'b1;
        @(negedge clk);
        s_start = 1'b0;
        s_wait_done("t5");
        chk("t5_done_once", 64'(s_done_cnt - d0), 64'd1);
        w0 = s_wr_cnt;
        s_inject_idle = 1'b1;
        repeat (5) @(negedge clk);
        chk("t5_idle_no_write", 64'(s_wr_cnt - w0), 64'd0);
        chk("t5_idle_no_done", 64'(s_done_cnt - d0), 64'd1);

        // Random buffer contents and random ready on the small instance.
        for (int i = 0; i < SN; i++) s_mem[i] = 16'($urandom);
        s_rand_ready = 1'b1;
        s_kick();
        s_wait_done("t5r");

        // Default-size map with random handshakes and latency.
        push_frame(1'b1);
        l_start = 1'b1;
        @(negedge clk);
        l_start = 1'b0;
        n = 0;
        while (l_done !== 1'b1 && n < 40000) begin
            @(negedge clk);
            n++;
        end
        if (l_done !== 1'b1) begin
            n_checks++; n_errors++;
            $display("FAIL t6_timeout: no done after %0d cycles, expected done", n);
        end
        repeat (3) @(negedge clk);
        chk("t6_writes", 64'(l_wr_cnt), 64'd400);
        chk("t6_done_once", 64'(l_done_cnt), 64'd1);
        chk("t6_busy_after", 64'(l_busy), 64'd0);
        chk("t6_wr_left", 64'(l_exp_wa.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
